// File: rtl/pulse_peak_detector.sv
// Threshold pulse detector: finds peak value, peak timestamp and width of each
// excursion above threshold, and queues one record per pulse in a small FIFO.
module pulse_peak_detector #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned HOLDOFF    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic                     enable,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_amplitude,
    output logic        [TS_W-1:0]   out_time,
    output logic        [7:0]        out_width,
    output logic        [7:0]        lost_count,
    output logic                     busy
);

    localparam int unsigned AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                    state;
    logic signed [DATA_W-1:0]  data_q;
    logic signed [DATA_W-1:0]  thr_q;
    logic        [TS_W-1:0]    ts;
    logic        [TS_W-1:0]    ts_q;
    logic signed [DATA_W-1:0]  peak;
    logic        [TS_W-1:0]    peak_time;
    logic        [CNT_W-1:0]   width;
    logic        [CNT_W-1:0]   hold_cnt;

    logic signed [DATA_W-1:0]  mem_amp   [FIFO_DEPTH];
    logic        [TS_W-1:0]    mem_time  [FIFO_DEPTH];
    logic        [CNT_W-1:0]   mem_width [FIFO_DEPTH];
    logic        [PW-1:0]      wr_ptr;
    logic        [PW-1:0]      rd_ptr;

    logic above_c;
    logic push_c;
    logic pop_c;
    logic full_c;
    logic wr_en_c;
    logic drop_c;

    assign above_c = data_q > thr_q;
    assign push_c  = (state == PULSE) && enable && !above_c;
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c   = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    assign out_valid     = (wr_ptr != rd_ptr);
    assign out_amplitude = mem_amp[rd_ptr[AW-1:0]];
    assign out_time      = mem_time[rd_ptr[AW-1:0]];
    assign out_width     = mem_width[rd_ptr[AW-1:0]];
    assign busy          = (state != IDLE);

    // Input registers; ts_q is the timestamp of the sample now held in data_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            thr_q  <= '0;
            ts     <= '0;
            ts_q   <= '0;
        end else begin
            data_q <= input_data;
            thr_q  <= threshold;
            ts     <= ts + TS_W'(1);
            ts_q   <= ts;
        end
    end

    // Detection FSM with peak/width tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            peak      <= '0;
            peak_time <= '0;
            width     <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && above_c) begin
                        state     <= PULSE;
                        peak      <= data_q;
                        peak_time <= ts_q;
                        width     <= CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (above_c) begin
                        if (width != CNT_MAX) begin
                            width <= width + CNT_W'(1);
                        end
                        // Strict compare keeps the earliest sample of a tie.
                        if (data_q > peak) begin
                            peak      <= data_q;
                            peak_time <= ts_q;
                        end
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LAST;
                    end
                end
                HOLD: begin
                    if (!enable || hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result FIFO and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lost_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_amp[i]   <= '0;
                mem_time[i]  <= '0;
                mem_width[i] <= '0;
            end
        end else begin
            if (wr_en_c) begin
                mem_amp[wr_ptr[AW-1:0]]   <= peak;
                mem_time[wr_ptr[AW-1:0]]  <= peak_time;
                mem_width[wr_ptr[AW-1:0]] <= width;
                wr_ptr                    <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop_c && lost_count != CNT_MAX) begin
                lost_count <= lost_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector: single pulse, plateau, holdoff,
// backpressure with drops, full-FIFO push/pop, abort and reset behaviour.
module tb_pulse_peak_detector;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TS_W   = 16;

    logic                     clk;
    logic                     reset;
    logic signed [DATA_W-1:0] input_data;
    logic signed [DATA_W-1:0] threshold;
    logic                     enable;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_amplitude;
    logic        [TS_W-1:0]   out_time;
    logic        [7:0]        out_width;
    logic        [7:0]        lost_count;
    logic                     busy;

    int errors;
    int checks;
    int tb_cyc;

    int rec_amp[$];
    int rec_time[$];
    int rec_width[$];
    int rec_cyc[$];

    pulse_peak_detector #(
        .DATA_W    (DATA_W),
        .TS_W      (TS_W),
        .HOLDOFF   (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .threshold    (threshold),
        .enable       (enable),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_amplitude(out_amplitude),
        .out_time     (out_time),
        .out_width    (out_width),
        .lost_count   (lost_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    // Advance one cycle, logging any record handed over in the cycle just left.
    task automatic tick_c();
        logic took;
        took = out_valid && out_ready;
        if (took) begin
            rec_amp.push_back(int'(out_amplitude));
            rec_time.push_back(int'(out_time));
            rec_width.push_back(int'(out_width));
            rec_cyc.push_back(tb_cyc);
        end
        tick();
    endtask

    task automatic idle(input int n);
        input_data = '0;
        repeat (n) tick();
    endtask

    task automatic clear_recs();
        rec_amp.delete();
        rec_time.delete();
        rec_width.delete();
        rec_cyc.delete();
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        enable     = 1'b0;
        out_ready  = 1'b0;
        input_data = '0;
        threshold  = '0;
        tb_cyc     = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b want 0 0", out_valid, busy);
        end
        checks++;
        if (lost_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_lost: got %0d want 0", lost_count);
        end
        checks++;
        if (out_amplitude !== 16'sd0 || out_time !== 16'd0 || out_width !== 8'd0) begin
            errors++;
            $display("FAIL reset_fields: amp=%0d time=%0d width=%0d want 0 0 0",
                     out_amplitude, out_time, out_width);
        end
        reset  = 1'b1;
        tb_cyc = 0;
    endtask

    task automatic test_single_pulse();
        int s[6] = '{0, 150, 300, 250, 80, 0};
        int t300;
        int n80;
        threshold = 16'sd100;
        enable    = 1'b1;
        out_ready = 1'b1;
        idle(3);
        clear_recs();
        t300 = 0;
        n80  = 0;
        for (int i = 0; i < 6; i++) begin
            input_data = 16'(s[i]);
            if (s[i] == 300) t300 = tb_cyc;
            if (s[i] == 80)  n80  = tb_cyc;
            tick_c();
        end
        input_data = '0;
        repeat (8) tick_c();
        checks++;
        if (rec_amp.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d records want 1", rec_amp.size());
        end else begin
            checks++;
            if (rec_amp[0] != 300 || rec_width[0] != 3) begin
                errors++;
                $display("FAIL single_fields: amp=%0d width=%0d want 300 3", rec_amp[0], rec_width[0]);
            end
            checks++;
            if (rec_time[0] != (t300 & 16'hFFFF)) begin
                errors++;
                $display("FAIL single_time: got %0d want %0d", rec_time[0], t300);
            end
            checks++;
            if (rec_cyc[0] != n80 + 2) begin
                errors++;
                $display("FAIL single_latency: valid in cycle %0d want %0d", rec_cyc[0], n80 + 2);
            end
        end
    endtask

    task automatic test_plateau();
        int t_first;
        int n_end;
        idle(12);
        clear_recs();
        t_first    = tb_cyc;
        input_data = 16'sd300;
        repeat (300) tick_c();
        input_data = '0;
        n_end      = tb_cyc;
        repeat (6) tick_c();
        checks++;
        if (rec_amp.size() != 1) begin
            errors++;
            $display("FAIL plateau_count: got %0d records want 1", rec_amp.size());
        end else begin
            checks++;
            if (rec_amp[0] != 300 || rec_width[0] != 255) begin
                errors++;
                $display("FAIL plateau_fields: amp=%0d width=%0d want 300 255", rec_amp[0], rec_width[0]);
            end
            checks++;
            if (rec_time[0] != (t_first & 16'hFFFF) || rec_cyc[0] != n_end + 2) begin
                errors++;
                $display("FAIL plateau_time: time=%0d cyc=%0d want %0d %0d",
                         rec_time[0], rec_cyc[0], t_first, n_end + 2);
            end
        end
    endtask

    task automatic test_holdoff();
        int seq[17] = '{200, 0, 0, 0, 250, 250, 250, 0, 0, 0, 260, 0, 0, 0, 0, 0, 0};
        int p;
        idle(12);
        clear_recs();
        p = tb_cyc;
        for (int i = 0; i < 17; i++) begin
            input_data = 16'(seq[i]);
            tick_c();
        end
        checks++;
        if (rec_amp.size() != 2) begin
            errors++;
            $display("FAIL holdoff_count: got %0d records want 2", rec_amp.size());
        end else begin
            checks++;
            if (rec_amp[0] != 200 || rec_amp[1] != 260) begin
                errors++;
                $display("FAIL holdoff_amps: got %0d %0d want 200 260", rec_amp[0], rec_amp[1]);
            end
            checks++;
            if (rec_time[1] != ((p + 10) & 16'hFFFF)) begin
                errors++;
                $display("FAIL holdoff_time: got %0d want %0d", rec_time[1], p + 10);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_t[6];
        int t500;
        int drain_amp[4];
        int drain_time[4];
        idle(12);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            input_data = 16'(200 + 10 * i);
            exp_t[i]   = tb_cyc;
            tick();
            idle(12);
            checks++;
            if (out_valid !== 1'b1 || out_amplitude !== 16'sd200 ||
                out_time !== 16'(exp_t[0]) || out_width !== 8'd1) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b amp=%0d time=%0d width=%0d want 1 200 %0d 1",
                         i, out_valid, out_amplitude, out_time, out_width, exp_t[0]);
            end
        end
        checks++;
        if (lost_count !== 8'd2) begin
            errors++;
            $display("FAIL bp_lost: got %0d want 2", lost_count);
        end

        // Push into the full FIFO in the same cycle the head is popped.
        input_data = 16'sd500;
        t500       = tb_cyc;
        tick();
        input_data = '0;
        tick();
        out_ready = 1'b1;
        checks++;
        if (out_amplitude !== 16'sd200) begin
            errors++;
            $display("FAIL full_pushpop_head: got %0d want 200", out_amplitude);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (lost_count !== 8'd2 || out_valid !== 1'b1 || out_amplitude !== 16'sd210) begin
            errors++;
            $display("FAIL full_pushpop: lost=%0d valid=%b amp=%0d want 2 1 210",
                     lost_count, out_valid, out_amplitude);
        end
        idle(10);

        drain_amp  = '{210, 220, 230, 500};
        drain_time = '{exp_t[1], exp_t[2], exp_t[3], t500};
        out_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_amplitude !== 16'(drain_amp[k]) ||
                out_time !== 16'(drain_time[k]) || out_width !== 8'd1) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b amp=%0d time=%0d width=%0d want 1 %0d %0d 1",
                         k, out_valid, out_amplitude, out_time, out_width, drain_amp[k], drain_time[k]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_abort();
        int seen;
        idle(12);
        out_ready  = 1'b1;
        input_data = 16'sd200;
        tick();
        input_data = 16'sd300;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy_after: got %b want 0", busy);
        end
        repeat (3) tick();
        input_data = '0;
        repeat (2) tick();
        enable = 1'b1;
        seen   = 0;
        repeat (15) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_record: valid cycles=%0d busy=%b want 0 0", seen, busy);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            input_data = 16'(200 + 10 * i);
            tick();
            idle(12);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_queued: valid=%b want 1", out_valid);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || lost_count !== 8'd0 || out_amplitude !== 16'sd0) begin
            errors++;
            $display("FAIL rst_mid_clear: valid=%b busy=%b lost=%0d amp=%0d want 0 0 0 0",
                     out_valid, busy, lost_count, out_amplitude);
        end
        repeat (2) tick();
        reset     = 1'b1;
        tb_cyc    = 0;
        out_ready = 1'b1;
        input_data = '0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_valid: got %b want 0", out_valid);
        end
        input_data = 16'sd150;
        tick();
        input_data = '0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_amplitude !== 16'sd150 || out_time !== 16'd2 || out_width !== 8'd1) begin
            errors++;
            $display("FAIL rst_restart_ts: valid=%b amp=%0d time=%0d width=%0d want 1 150 2 1",
                     out_valid, out_amplitude, out_time, out_width);
        end
        idle(4);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_pulse();
        test_plateau();
        test_holdoff();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pulse_peak_detector.md
PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 Parameter DATA_W, default 16 (SIZE_FILTER_DATA), sets the width of the signed two's-complement filter sample.
REQ-002 Parameter TS_W, default 16, sets the timestamp counter width.
REQ-003 Parameter HOLDOFF, default 8, sets the dead-time cycles after each pulse end; legal range is 1..255.
REQ-004 Parameter FIFO_DEPTH, default 4, sets the result FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-005 clk  in  1  single clock for the block; all logic SHALL be clocked on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 input_data  in  DATA_W  signed filter sample, one sample per clk.
REQ-008 threshold  in  DATA_W  signed trigger level; it SHALL be sampled every cycle.
REQ-009 enable  in  1  detection enable; low SHALL abort any pulse in progress and hold the FSM in IDLE.
REQ-010 out_ready  in  1  consumer accepts the head-of-FIFO record.
REQ-011 out_valid  out  1  the head-of-FIFO record is valid.
REQ-012 out_amplitude  out  DATA_W  signed peak sample value.
REQ-013 out_time  out  TS_W  timestamp of the peak sample.
REQ-014 out_width  out  8  count of samples above threshold, saturating at 255.
REQ-015 lost_count  out  8  count of records dropped because the FIFO was full, saturating at 255.
REQ-016 busy  out  1  high while the FSM is not in IDLE.

Function
REQ-017 The timestamp counter SHALL be free-running, increment by 1 every cycle, wrap from 2^TS_W-1 to 0, and be 0 in the first cycle after reset release.
REQ-018 A sample's timestamp SHALL be the counter value in the cycle that sample is presented on input_data.
REQ-019 input_data and threshold SHALL be registered once; all comparisons SHALL be signed and use the registered values.
REQ-020 The FSM SHALL have three states: IDLE, PULSE and HOLD.
REQ-021 IDLE to PULSE SHALL occur when enable=1 and the sample > threshold (strictly greater).
  - On entry: peak = sample, peak_time = its timestamp, width = 1.
REQ-022 While in PULSE, each sample > threshold SHALL increment width (saturating at 255).
  - If sample > peak, peak and peak_time SHALL update.
  - On a tie, the earliest peak SHALL be kept.
REQ-023 PULSE to HOLD SHALL occur on the first sample <= threshold.
  - In that same transition, the record {peak, peak_time, width} SHALL be pushed into the FIFO if it is not full.
  - If the FIFO is full, the record SHALL be dropped and lost_count SHALL increment, saturating at 255.
REQ-024 HOLD SHALL ignore input for exactly HOLDOFF cycles, then return to IDLE; a sample above threshold in the IDLE cycle SHALL start a new pulse.
REQ-025 enable=0 in any state SHALL force IDLE on the next edge.
  - Any pulse in progress SHALL be discarded without a push.
  - FIFO contents and lost_count SHALL be unaffected.
REQ-026 Latency: if the end sample (<= threshold) is presented in cycle n and the FIFO is empty, out_valid SHALL be 1 in cycle n+2.
REQ-027 Output handshake: a pop SHALL occur in a cycle where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, the output fields SHALL hold stable.
REQ-028 A simultaneous push and pop on a full FIFO SHALL accept the push; no drop occurs and the occupancy is unchanged.
REQ-029 A simultaneous push and pop on an empty FIFO is impossible, since out_valid=0; the pushed record SHALL appear the next cycle.
REQ-030 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-031 out_amplitude, out_time and out_width SHALL be driven directly from the head FIFO entry and are don't-care when out_valid=0.

Reset
REQ-032 While reset=0, the block SHALL be in the following state:
  - FSM in IDLE;
  - timestamp counter = 0;
  - FIFO empty;
  - out_valid = 0, busy = 0, lost_count = 0;
  - out_amplitude, out_time and out_width = 0;
  - input registers = 0.
REQ-033 Reset asserted mid-pulse or mid-handshake SHALL discard all state immediately, with no record emitted after release.

Verification
REQ-034 Single pulse: threshold=100, input 0,150,300,250,80,0 with out_ready=1 -> exactly one record: amplitude=300, width=3, out_time = timestamp of the 300 sample; out_valid goes high 2 cycles after the 80 sample.
REQ-035 Tie and saturation: a plateau of 300 repeated 300 cycles -> out_time = first 300 sample, width=255.
REQ-036 Backpressure: out_ready=0 and six pulses separated by more than HOLDOFF cycles (FIFO_DEPTH=4) -> 4 records held stable and lost_count=2; then out_ready=1 -> 4 records popped in order.
REQ-037 Holdoff: HOLDOFF=8; a second excursion starting 3 cycles after a pulse end is ignored; one starting 9 cycles after is detected.
REQ-038 Abort and reset: enable dropped mid-pulse -> no record, busy=0 next cycle; reset asserted with 2 queued records -> out_valid=0 immediately, and the counter restarts at 0 after release.
